divider_32: RTL and testbench



---
 rtl/divider_pkg.sv | 14 +
 rtl/divider_32_if.sv | 34 +++
 rtl/divider_32_step.sv | 25 ++
 rtl/divider_32.sv | 161 ++++++++++++++++
 tb/tb_divider_32.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Signed operation is compiled in only when DIVIDER_SIGNED_EN is defined.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_32_if.sv
// Request/result bundle between the ALU issue logic and the divider.
// The sign select exists only when DIVIDER_SIGNED_EN is defined.
interface divider_32_if #(
    parameter int WIDTH = divider_pkg::DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef DIVIDER_SIGNED_EN
    logic             sign;
`endif
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
`ifdef DIVIDER_SIGNED_EN
        output sign,
`endif
        output start, a, b,
        input  q, r, busy, done, dbz
    );

    modport slave (
`ifdef DIVIDER_SIGNED_EN
        input  sign,
`endif
        input  start, a, b,
        output q, r, busy, done, dbz
    );

endinterface

// File: rtl/divider_32_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < divisor_i always holds, so the shifted value fits WIDTH+1 bits
    // and a non-negative difference fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {1'b0, divisor_i};
        qbit_o  = ~diff[WIDTH];
        rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_32.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Optional: define DIVIDER_SIGNED_EN for signed (truncating) division.
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero resolved here directly
// CALC  | WIDTH iterations of the restoring step
// DONE  | one-cycle done pulse, then back to IDLE
module divider_32
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    divider_32_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // The dividend register doubles as the quotient: bits shift out the top
    // into the remainder while quotient bits shift in at the bottom.
    assign q_raw = {dvd_q[WIDTH-2:0], step_qbit};

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // Operands become magnitudes at accept; the most-negative value maps to
    // itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        q_fix = neg_q_q ? -q_raw : q_raw;
        r_fix = neg_r_q ? -step_rem : step_rem;
    end
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
    assign q_fix = q_raw;
    assign r_fix = step_rem;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        q_d     = '1;
                        r_d     = bus.a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        neg_q_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r_d = bus.sign & bus.a[WIDTH-1];
`endif
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = q_raw;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    q_d     = q_fix;
                    r_d     = r_fix;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dbz  = dbz_q;
    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_divider_32.sv
// Randomized and directed bench for divider_32 against a plain-arithmetic
// reference. Signed cases are exercised when DIVIDER_SIGNED_EN is defined.
module tb_divider_32;
    import divider_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_32_if bus ();

    divider_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: integer division straight from the arithmetic definition.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        z = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive_sign(input logic sgn);
`ifdef DIVIDER_SIGNED_EN
        bus.sign = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    // One full operation: start, optional mid-run re-pulse, then checks on
    // latency, busy length, results and the ignored back-to-back start.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int repulse_at);
        logic [31:0] eq, er;
        logic        ez;
        int          edges;
        int          nbusy;
        bit          got;
        ref_div(a, b, sgn, eq, er, ez);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        drive_sign(sgn);
        edges = 0;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            if (i == repulse_at) begin
                bus.start = 1'b1;
                bus.a     = 32'd50;
                bus.b     = 32'd5;
            end
            if (i == repulse_at + 1) bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            edges++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges), ez ? 32'd0 : 32'd32);
        check({tag, "_busy_cycles"}, 32'(nbusy), ez ? 32'd0 : 32'd32);
        check({tag, "_q"}, bus.q, eq);
        check({tag, "_r"}, bus.r, er);
        check({tag, "_dbz"}, 32'(bus.dbz), 32'(ez));
        // start during the done cycle must be dropped
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_b2b_not_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_q_held"}, bus.q, eq);
        check({tag, "_dbz_held"}, 32'(bus.dbz), 32'(ez));
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        drive_sign(1'b0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_q", bus.q, 32'd0);
        check("midrst_r", bus.r, 32'd0);
        check("midrst_dbz", 32'(bus.dbz), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        drive_sign(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_q", bus.q, 32'd0);
        check("rst_r", bus.r, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.dbz), 32'd0);
        rst = 1'b0;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, -10);
        run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, -10);
        run_op("u5_9", 32'd5, 32'd9, 1'b0, -10);
        run_op("u5_0", 32'd5, 32'd0, 1'b0, -10);
        run_op("dbz_clear", 32'd81, 32'd9, 1'b0, -10);
        run_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -10);
        run_op("u_big_div", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, -10);
        run_op("repulse", 32'd100, 32'd7, 1'b0, 10);
`ifdef DIVIDER_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -10);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -10);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, -10);
        run_op("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, -10);
        run_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, -10);
        run_op("s_m7_2_uns", 32'hFFFF_FFF9, 32'd2, 1'b0, -10);
`endif
        reset_mid_run();
        run_op("after_rst", 32'd100, 32'd7, 1'b0, -10);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
`ifdef DIVIDER_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rnd%0d", k), ra, rb, rs, -10);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
